// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states and owner ids.
package ysyx_25040111_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic OWN_ICACHE = 1'b0;
  localparam logic OWN_LSU    = 1'b1;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker.
// On a tie the master that did not own the previous transaction wins.
module ysyx_25040111_rr_pick
  import ysyx_25040111_mem_arbiter_pkg::*;
(
  input  logic i_vld0,
  input  logic i_vld1,
  input  logic i_last_owner,
  output logic o_grant,
  output logic o_owner
);

  assign o_grant = i_vld0 | i_vld1;

  always_comb begin
    o_owner = OWN_ICACHE;
    if (i_vld0 && i_vld1) begin
      o_owner = ~i_last_owner;
    end else if (i_vld1) begin
      o_owner = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Icache/LSU to single memory port arbiter: one outstanding transaction,
// round-robin grant held across every beat of a burst.
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [LW-1:0]   m0_req_len,
  output logic            m0_rsp_valid,
  output logic            m0_rsp_last,
  output logic [DW-1:0]   m0_rsp_data,

  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic            m1_req_write,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rsp_data,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_write,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  output logic [LW-1:0]   mem_req_len,
  input  logic            mem_rsp_valid,
  input  logic            mem_rsp_last,
  input  logic [DW-1:0]   mem_rsp_data
);

  arb_state_t      r_state;
  logic            r_owner;
  logic            r_last_owner;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [LW-1:0]   r_len;

  logic w_grant;
  logic w_owner;
  logic w_take;
  logic w_resp_m0;
  logic w_resp_m1;
  logic w_done;

  ysyx_25040111_rr_pick u_pick (
    .i_vld0       (m0_req_valid),
    .i_vld1       (m1_req_valid),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant),
    .o_owner      (w_owner)
  );

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign w_take       = reset && (r_state == ST_IDLE) && w_grant;
  assign m0_req_ready = w_take && (w_owner == OWN_ICACHE);
  assign m1_req_ready = w_take && (w_owner == OWN_LSU);

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_write = r_write;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;
  assign mem_req_len   = r_len;

  assign w_resp_m0 = (r_state == ST_RESP) && (r_owner == OWN_ICACHE) && mem_rsp_valid;
  assign w_resp_m1 = (r_state == ST_RESP) && (r_owner == OWN_LSU) && mem_rsp_valid;
  assign w_done    = (r_state == ST_RESP) && mem_rsp_valid && mem_rsp_last;

  assign m0_rsp_valid = w_resp_m0;
  assign m0_rsp_last  = w_resp_m0 && mem_rsp_last;
  assign m0_rsp_data  = w_resp_m0 ? mem_rsp_data : '0;
  assign m1_rsp_valid = w_resp_m1;
  assign m1_rsp_data  = (w_resp_m1 && !r_write) ? mem_rsp_data : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_ICACHE;
      r_last_owner <= OWN_LSU;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_len        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_owner;
            r_state <= ST_REQ;
            if (w_owner == OWN_ICACHE) begin
              r_write <= 1'b0;
              r_addr  <= m0_req_addr;
              r_wdata <= '0;
              r_wstrb <= '0;
              r_len   <= m0_req_len;
            end else begin
              r_write <= m1_req_write;
              r_addr  <= m1_req_addr;
              r_wdata <= m1_req_wdata;
              r_wstrb <= m1_req_wstrb;
              r_len   <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_done) begin
            r_last_owner <= r_owner;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A beat before the request handshake would be routed nowhere.
  a_no_early_rsp: assert property (@(posedge clock) disable iff (!reset)
    !((r_state == ST_REQ) && mem_rsp_valid));

endmodule
